// File: rtl/mips_perf_monitor_if.sv
// Read port of the performance monitor: a request channel (index in) and a
// response channel (counter value out), each with its own valid/ready pair.
interface mips_perf_monitor_if #(
  parameter int CNT_WIDTH = 32
) ();
  logic                 rd_req_valid;
  logic [3:0]           rd_req_addr;
  logic                 rd_req_ready;
  logic                 rd_resp_valid;
  logic [CNT_WIDTH-1:0] rd_resp_data;
  logic                 rd_resp_ready;

  // Reader side (software or bench) issues requests and consumes responses.
  modport master (
    output rd_req_valid, rd_req_addr, rd_resp_ready,
    input  rd_req_ready, rd_resp_valid, rd_resp_data
  );

  // Monitor side accepts requests and produces responses.
  modport slave (
    input  rd_req_valid, rd_req_addr, rd_resp_ready,
    output rd_req_ready, rd_resp_valid, rd_resp_data
  );
endinterface

// File: rtl/mips_perf_monitor.sv
// Performance counters fed by the CPU retire strobe and eight event strobes.
// Live counters wrap with sticky overflow flags; a snapshot copy is exposed
// through a three-state read port so a coherent set can be read while live
// counting carries on.
module mips_perf_monitor #(
  parameter int CNT_WIDTH = 32,
  parameter int NUM_EVT   = 8
) (
  input  logic               mips_cpu_clk,
  input  logic               mips_cpu_reset_n,
  input  logic               mips_cpu_pc_sig,
  input  logic [NUM_EVT-1:0] mips_cpu_perf_sig,
  input  logic               cfg_enable,
  input  logic               cfg_clear,
  input  logic               snap_req,
  mips_perf_monitor_if.slave rd_bus,
  output logic [NUM_EVT+1:0] ovf_flags
);

  // Counter 0 = cycles, 1 = instret, 2.. = event strobes; one extra address
  // past the last counter returns the overflow flags.
  localparam int         NUM_CNT  = NUM_EVT + 2;
  localparam logic [3:0] OVF_ADDR = 4'(NUM_CNT);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_e;

  logic [NUM_CNT-1:0]   inc;
  logic [CNT_WIDTH-1:0] cnt_q    [NUM_CNT];
  logic [CNT_WIDTH-1:0] cnt_d    [NUM_CNT];
  logic [CNT_WIDTH-1:0] shadow_q [NUM_CNT];
  logic [NUM_CNT-1:0]   ovf_q, ovf_d;

  state_e               state_q, state_d;
  logic [3:0]           addr_q;
  logic [CNT_WIDTH-1:0] data_q, sel_data;
  // Zero-extended flags so the flag word fits any counter width.
  logic [CNT_WIDTH+NUM_CNT-1:0] ovf_ext;

  assign inc     = {NUM_CNT{cfg_enable}} & {mips_cpu_perf_sig, mips_cpu_pc_sig, 1'b1};
  assign ovf_ext = {{CNT_WIDTH{1'b0}}, ovf_q};

  // Next live counter values: clear beats increment and the overflow it would cause.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (cfg_clear) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (inc[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
        if (cnt_q[i] == '1) ovf_d[i] = 1'b1;
      end
    end
  end

  // Live counters and sticky overflow flags.
  always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
    if (!mips_cpu_reset_n) begin
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= cnt_d[i];
      ovf_q <= ovf_d;
    end
  end

  // Shadow copy takes the pre-increment, pre-clear live values.
  always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
    if (!mips_cpu_reset_n) begin
      for (int i = 0; i < NUM_CNT; i++) shadow_q[i] <= '0;
    end else if (snap_req) begin
      for (int i = 0; i < NUM_CNT; i++) shadow_q[i] <= cnt_q[i];
    end
  end

  // Read mux over the latched address: shadows, then flags, then zeros.
  always_comb begin
    sel_data = '0;
    if (addr_q < OVF_ADDR)       sel_data = shadow_q[addr_q];
    else if (addr_q == OVF_ADDR) sel_data = ovf_ext[CNT_WIDTH-1:0];
  end

  // Read FSM state register.
  always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
    if (!mips_cpu_reset_n) state_q <= IDLE;
    else                   state_q <= state_d;
  end

  // Read FSM next-state: accept, look up for one cycle, hold until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_bus.rd_req_valid) state_d = LOOKUP;
      LOOKUP:  state_d = RESP;
      RESP:    if (rd_bus.rd_resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read FSM outputs decoded from the current state.
  always_comb begin
    rd_bus.rd_req_ready  = (state_q == IDLE);
    rd_bus.rd_resp_valid = (state_q == RESP);
  end

  // Address latched on accept; data latched once in LOOKUP so later snapshots
  // cannot disturb a response already in flight.
  always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
    if (!mips_cpu_reset_n) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (state_q == IDLE && rd_bus.rd_req_valid) addr_q <= rd_bus.rd_req_addr;
      if (state_q == LOOKUP) data_q <= sel_data;
    end
  end

  assign rd_bus.rd_resp_data = data_q;
  assign ovf_flags           = ovf_q;

endmodule

// File: tb/tb_mips_perf_monitor.sv
// Directed bench for mips_perf_monitor, built with 8-bit counters so that
// wrap-around is reachable in a few hundred cycles.
module tb_mips_perf_monitor;
  localparam int CW = 8;

  logic       clk;
  logic       rst_n;
  logic       pc_sig;
  logic [7:0] perf_sig;
  logic       cfg_enable;
  logic       cfg_clear;
  logic       snap_req;
  logic [9:0] ovf_flags;

  int errors = 0;
  int checks = 0;

  mips_perf_monitor_if #(.CNT_WIDTH(CW)) bus ();

  mips_perf_monitor #(.CNT_WIDTH(CW), .NUM_EVT(8)) dut (
    .mips_cpu_clk      (clk),
    .mips_cpu_reset_n  (rst_n),
    .mips_cpu_pc_sig   (pc_sig),
    .mips_cpu_perf_sig (perf_sig),
    .cfg_enable        (cfg_enable),
    .cfg_clear         (cfg_clear),
    .snap_req          (snap_req),
    .rd_bus            (bus.slave),
    .ovf_flags         (ovf_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full read transaction: accept, LOOKUP (valid low), RESP (valid high, data).
  task automatic do_read(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    check({tag, ".req_ready"}, {31'b0, bus.rd_req_ready}, 32'd1);
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = addr;
    tick();
    bus.rd_req_valid = 1'b0;
    check({tag, ".lookup_valid"}, {31'b0, bus.rd_resp_valid}, 32'd0);
    tick();
    check({tag, ".resp_valid"}, {31'b0, bus.rd_resp_valid}, 32'd1);
    check({tag, ".data"}, {24'b0, bus.rd_resp_data}, exp);
    bus.rd_resp_ready = 1'b1;
    tick();
    bus.rd_resp_ready = 1'b0;
    check({tag, ".idle_valid"}, {31'b0, bus.rd_resp_valid}, 32'd0);
    $display("read %s addr=%0d data=%0h expected=%0h", tag, addr, bus.rd_resp_data, exp);
  endtask

  task automatic run_enabled(input int n, input logic pc, input logic [7:0] perf);
    cfg_enable = 1'b1;
    pc_sig     = pc;
    perf_sig   = perf;
    for (int i = 0; i < n; i++) tick();
    cfg_enable = 1'b0;
    pc_sig     = 1'b0;
    perf_sig   = 8'h00;
  endtask

  task automatic pulse_snap();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
  endtask

  task automatic pulse_clear();
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_evt [8];

    rst_n             = 1'b0;
    pc_sig            = 1'b0;
    perf_sig          = 8'h00;
    cfg_enable        = 1'b0;
    cfg_clear         = 1'b0;
    snap_req          = 1'b0;
    bus.rd_req_valid  = 1'b0;
    bus.rd_req_addr   = 4'd0;
    bus.rd_resp_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst.req_ready", {31'b0, bus.rd_req_ready}, 32'd1);
    check("rst.resp_valid", {31'b0, bus.rd_resp_valid}, 32'd0);
    check("rst.resp_data", {24'b0, bus.rd_resp_data}, 32'd0);
    check("rst.ovf", {22'b0, ovf_flags}, 32'd0);
    rst_n = 1'b1;

    // 100 enabled cycles, retire strobe on the first 40
    cfg_enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      pc_sig = (i < 40);
      tick();
    end
    cfg_enable = 1'b0;
    pc_sig     = 1'b0;
    pulse_snap();
    do_read("cycles", 4'd0, 32'd100);
    do_read("instret", 4'd1, 32'd40);
    check("t1.ovf", {22'b0, ovf_flags}, 32'd0);

    // Event strobes 8'hA5 for 10 cycles
    run_enabled(10, 1'b0, 8'hA5);
    pulse_snap();
    exp_evt = '{32'd10, 32'd0, 32'd10, 32'd0, 32'd0, 32'd10, 32'd0, 32'd10};
    for (int i = 0; i < 8; i++)
      do_read($sformatf("evt%0d", i), 4'(i + 2), exp_evt[i]);

    // Wrap: 256 increments from zero overflow counters 0 and 1
    pulse_clear();
    run_enabled(256, 1'b1, 8'h00);
    check("wrap.ovf", {22'b0, ovf_flags}, 32'h003);
    pulse_snap();
    do_read("wrap.instret", 4'd1, 32'd0);
    do_read("wrap.flags", 4'd10, 32'h03);

    // Counter at all-ones, then clear with a simultaneous strobe
    pulse_clear();
    check("clr.ovf", {22'b0, ovf_flags}, 32'd0);
    run_enabled(255, 1'b1, 8'h00);
    pulse_snap();
    do_read("pre_wrap.instret", 4'd1, 32'hFF);
    cfg_enable = 1'b1;
    pc_sig     = 1'b1;
    cfg_clear  = 1'b1;
    tick();
    cfg_enable = 1'b0;
    pc_sig     = 1'b0;
    cfg_clear  = 1'b0;
    check("clr_wins.ovf", {22'b0, ovf_flags}, 32'd0);
    pulse_snap();
    do_read("clr_wins.instret", 4'd1, 32'd0);
    do_read("clr_wins.cycles", 4'd0, 32'd0);

    // Snapshot and clear in the same cycle keep the pre-clear value
    run_enabled(57, 1'b0, 8'h00);
    snap_req  = 1'b1;
    cfg_clear = 1'b1;
    tick();
    snap_req  = 1'b0;
    cfg_clear = 1'b0;
    do_read("snapclr.shadow", 4'd0, 32'd57);
    pulse_snap();
    do_read("snapclr.live", 4'd0, 32'd0);

    // Backpressure: live cycles = 5, shadow still 0 when the read starts
    run_enabled(5, 1'b0, 8'h00);
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = 4'd0;
    tick();
    bus.rd_req_valid  = 1'b0;
    bus.rd_resp_ready = 1'b1;   // ignored outside RESP
    snap_req          = 1'b1;   // lands while in LOOKUP
    tick();
    bus.rd_resp_ready = 1'b0;
    check("bp.valid0", {31'b0, bus.rd_resp_valid}, 32'd1);
    check("bp.data0", {24'b0, bus.rd_resp_data}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      bus.rd_req_valid = 1'b1;
      bus.rd_req_addr  = 4'd3;
      tick();
      check($sformatf("bp.valid%0d", i + 1), {31'b0, bus.rd_resp_valid}, 32'd1);
      check($sformatf("bp.data%0d", i + 1), {24'b0, bus.rd_resp_data}, 32'd0);
      check($sformatf("bp.req_ready%0d", i + 1), {31'b0, bus.rd_req_ready}, 32'd0);
    end
    snap_req          = 1'b0;
    bus.rd_req_valid  = 1'b0;
    bus.rd_resp_ready = 1'b1;
    tick();
    bus.rd_resp_ready = 1'b0;
    check("bp.release", {31'b0, bus.rd_resp_valid}, 32'd0);
    $display("read bp addr=0 data held through backpressure");
    do_read("bp.after", 4'd0, 32'd5);
    do_read("addr12", 4'd12, 32'd0);

    // Asynchronous reset while a response is pending
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = 4'd0;
    tick();
    bus.rd_req_valid = 1'b0;
    tick();
    check("rr.valid", {31'b0, bus.rd_resp_valid}, 32'd1);
    check("rr.data", {24'b0, bus.rd_resp_data}, 32'd5);
    rst_n = 1'b0;
    #1;
    check("rr.async_valid", {31'b0, bus.rd_resp_valid}, 32'd0);
    check("rr.async_ready", {31'b0, bus.rd_req_ready}, 32'd1);
    check("rr.async_data", {24'b0, bus.rd_resp_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_read("rr.cycles", 4'd0, 32'd0);
    do_read("rr.instret", 4'd1, 32'd0);
    do_read("rr.evt0", 4'd2, 32'd0);
    do_read("rr.flags", 4'd10, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_perf_monitor.md
Name: mips_perf_monitor

Overview:
- Performance-counter unit directly downstream of mips_cpu_top.
- Consumes the CPU's instruction-retire strobe (mips_cpu_pc_sig) and 8 event strobes (mips_cpu_perf_sig) and accumulates them in wrap-around counters with sticky overflow flags.
- Exposes a shadow (snapshot) copy of the counters through a valid/ready request/response read port, so software or the bench reads a coherent set while live counting continues.

Parameters:
- CNT_WIDTH, 32, width of every counter and of rd_resp_data.
- NUM_EVT, 8, number of perf_sig event strobes; fixed to 8 in this revision.

Ports:
- mips_cpu_clk  input  1  single system clock, rising edge.
- mips_cpu_reset_n  input  1  asynchronous, active-low reset.
- mips_cpu_pc_sig  input  1  instruction-retire strobe; one cycle high per retired instruction.
- mips_cpu_perf_sig  input  8  per-event strobes; bit i is counted by counter i+2.
- cfg_enable  input  1  counting enable (level).
- cfg_clear  input  1  single-cycle pulse; zeroes the live counters and the overflow flags.
- snap_req  input  1  single-cycle pulse; copies the live counters into the shadow registers.
- rd_req_valid  input  1  read request valid.
- rd_req_addr  input  4  counter index.
- rd_req_ready  output  1  request accepted when rd_req_valid and rd_req_ready are both high.
- rd_resp_valid  output  1  response data valid.
- rd_resp_data  output  CNT_WIDTH  response data.
- rd_resp_ready  input  1  consumer accepts the response.
- ovf_flags  output  10  sticky overflow flag per counter.

Behaviour:
- Clock and reset: one clock (mips_cpu_clk); reset is asynchronous and active-low (mips_cpu_reset_n).
- Counter map:
  - Counter 0: cycle count; +1 on every cycle with cfg_enable=1.
  - Counter 1: instret; +1 when cfg_enable=1 and mips_cpu_pc_sig=1.
  - Counters 2..9: +1 when cfg_enable=1 and mips_cpu_perf_sig[idx-2]=1.
  - All inputs are synchronous to mips_cpu_clk and sampled without a synchroniser.
- Increment and overflow:
  - Increment is visible in the live counter on the edge at which the strobe is sampled.
  - Counters wrap modulo 2^CNT_WIDTH.
  - The cycle of wrap (all-ones to 0) sets the matching ovf_flags bit; the bit stays set until clear or reset.
- cfg_clear:
  - On the next edge, live counters = 0 and ovf_flags = 0.
  - Clear wins over a same-cycle increment, and over an overflow that same cycle.
  - Shadow registers are unaffected.
- snap_req:
  - Shadow[i] takes the live counter value before that cycle's increment and before that cycle's clear.
  - snap_req and cfg_clear in the same cycle: shadow gets the pre-clear values.
- cfg_enable=0: live counters hold; snapshot, clear and read still work.
- Read address map:
  - Addresses 0..9 read shadow[addr].
  - Address 10 reads {22'b0, ovf_flags} (live flags).
  - Addresses 11..15 read 0.
- Read FSM, states IDLE, LOOKUP, RESP:
  - IDLE: rd_req_ready=1, rd_resp_valid=0. On rd_req_valid, latch the address and go to LOOKUP.
  - LOOKUP: rd_req_ready=0. Register the selected data into rd_resp_data; go to RESP.
  - RESP: rd_resp_valid=1 and rd_resp_data held stable until rd_resp_ready=1; that edge returns to IDLE.
  - Latency: rd_resp_valid rises 2 cycles after request acceptance.
  - Minimum throughput: one read per 3 cycles.
  - Snapshot updates while in LOOKUP/RESP do not alter already-latched rd_resp_data.
  - rd_resp_ready asserted outside RESP is ignored.
- Reset (asynchronous, at any time including mid-read):
  - All counters, shadows, ovf_flags and rd_resp_data go to 0.
  - FSM goes to IDLE, so rd_req_ready=1 and rd_resp_valid=0.
  - Any pending request is dropped.

Test Plan:
- Reset release, cfg_enable=1 for 100 cycles, mips_cpu_pc_sig high on 40 of them, snap_req, read addr 0 and 1 -> rd_resp_data = 100 (±snap-edge alignment: exactly the pre-snap count) and 40; rd_resp_valid rises 2 cycles after accept.
- perf_sig=8'hA5 held for 10 enabled cycles, snap, read addrs 2..9 -> 10,0,10,0,0,10,0,10.
- Force counter 1 near wrap (pulse pc_sig 2^CNT_WIDTH-... via bench with CNT_WIDTH=8): 256 retires -> counter 1 = 0, read addr 10 -> bit1=1; cfg_clear with simultaneous strobe -> counter 1 = 0, ovf bit1 = 0.
- snap_req and cfg_clear same cycle with live counter 0 = 57 -> shadow[0] = 57, live = 0; subsequent read addr 0 returns 57.
- Read backpressure: hold rd_resp_ready=0 for 5 cycles while issuing snap_req -> rd_resp_valid stays 1, rd_resp_data unchanged; rd_req_ready=0 throughout; addr 12 read returns 0.
- Assert mips_cpu_reset_n=0 while in RESP -> rd_resp_valid falls immediately, rd_req_ready=1, all reads after release return 0.
